// File: rtl/add_accumulator.sv
// Run-length accumulator: sums `len` operands into an N-bit result with sticky
// unsigned-carry and signed-overflow flags, then holds the result until accepted.
module add_accumulator #(
  parameter int N     = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [N-1:0]     acc;
  logic             carry_q;
  logic             ovf_q;
  logic [LEN_W-1:0] remaining;

  logic [N:0]       sum_ext;
  logic             add_ovf;

  always_comb begin
    sum_ext = {1'b0, acc} + {1'b0, in_data};
    add_ovf = (acc[N-1] == in_data[N-1]) && (sum_ext[N-1] != acc[N-1]);
  end

  // Handshakes: a transfer happens on any rising edge where valid && ready
  // are both high; ready/valid come from the registered state only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            remaining <= len;
            state     <= (len == '0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc       <= sum_ext[N-1:0];
            carry_q   <= carry_q | sum_ext[N];
            ovf_q     <= ovf_q | add_ovf;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) state <= DONE;
          end
        end
        DONE: begin
          // start is deliberately ignored here, including on the accept cycle
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready     = (state == ACCUM);
  assign out_valid    = (state == DONE);
  assign busy         = (state != IDLE);
  assign out_sum      = acc;
  assign out_carry    = carry_q;
  assign out_overflow = ovf_q;
  assign state_dbg    = state;

endmodule

// File: doc/add_accumulator.md
ADD_ACCUMULATOR -- requirements
Module: add_accumulator

Interface
REQ-001 Parameter N, default 32, data width of operands and sum.
REQ-002 Parameter LEN_W, default 8, width of the operand-count field.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin an accumulation run; sampled only in IDLE.
REQ-006 len  input  LEN_W  number of operands in the run; sampled with start.
REQ-007 busy  output  1  high while a run is in progress or a result is pending.
REQ-008 in_data  input  N  operand to be added.
REQ-009 in_valid  input  1  in_data holds a valid operand.
REQ-010 in_ready  output  1  block accepts an operand this cycle.
REQ-011 out_sum  output  N  accumulated sum, modulo 2^N.
REQ-012 out_carry  output  1  sticky unsigned carry-out of any addition in the run.
REQ-013 out_overflow  output  1  sticky signed (two's-complement) overflow of any addition in the run.
REQ-014 out_valid  output  1  out_sum and flags hold a completed result.
REQ-015 out_ready  input  1  consumer accepts the result this cycle.

Function
REQ-016 The block SHALL implement a three-state FSM: IDLE, ACCUM, DONE.
REQ-017 IDLE: in_ready=0, out_valid=0, busy=0; start=1 SHALL clear acc and both flags, load remaining<=len, and go to ACCUM, or to DONE if len==0.
REQ-018 start and len SHALL be ignored in ACCUM and DONE.
REQ-019 ACCUM: in_ready=1, busy=1; a transfer occurs on a cycle with in_valid && in_ready.
REQ-020 On each transfer: acc<=acc+in_data mod 2^N; carry|=bit N of the (N+1)-bit sum; overflow|=(acc[N-1]==in_data[N-1]) && (sum[N-1]!=acc[N-1]); remaining<=remaining-1.
REQ-021 No transfer SHALL leave acc, flags and remaining unchanged; gaps in in_valid are legal.
REQ-022 A transfer with remaining==1 SHALL move the FSM to DONE; out_valid SHALL be asserted on the following cycle.
REQ-023 DONE: out_valid=1, busy=1, in_ready=0; out_sum=acc, out_carry, out_overflow SHALL be held stable until accepted.
REQ-024 On out_valid && out_ready the FSM SHALL return to IDLE next cycle; start asserted on the accept cycle SHALL be ignored.
REQ-025 out_sum and flags SHALL retain their last values in IDLE until the next start clears them.
REQ-026 Maximum run length is 2^LEN_W-1 operands; len wrap-around is not supported.
REQ-027 in_ready, out_valid and busy SHALL be decoded from the registered state only, with no combinational input-to-output path.

Reset
REQ-028 reset=1 SHALL take priority over all other inputs in any state.
REQ-029 On reset: state=IDLE, acc=0, remaining=0, carry=0, overflow=0; out_sum=0, out_carry=0, out_overflow=0, out_valid=0, in_ready=0, busy=0 on the following cycle.
REQ-030 A run interrupted by reset SHALL be discarded with no result presented.

Verification
REQ-031 len=3, in_data 1000, 5678, 1 (back-to-back) -> out_valid asserted 1 cycle after third transfer, out_sum=6679, carry=0, overflow=0.
REQ-032 len=2, 0xFFFFFFFF then 0x00000002 -> out_sum=0x00000001, out_carry=1, out_overflow=0.
REQ-033 len=2, 0x7FFFFFFF then 0x00000001 -> out_sum=0x80000000, out_carry=0, out_overflow=1.
REQ-034 start with len=0 -> out_valid=1 on the next cycle, out_sum=0, flags 0, and in_ready never asserted.
REQ-035 In DONE, hold out_ready=0 for 5 cycles while pulsing start and in_valid -> out_valid, out_sum and flags stable and no transfer occurs; out_ready=1 -> IDLE next cycle.
REQ-036 len=3 with a 2-cycle in_valid gap, then reset after the 2nd transfer -> all outputs 0 next cycle; a new run with len=1, in_data 5 -> out_sum=5.
